// File: rtl/io_in_buf_wait.sv
// Input buffer FIFO with registered ready/valid handshake on both sides; any depth >= 1.
// Optional occupancy/high-water-mark ports are enabled by defining IO_IN_BUF_LEVEL_EN.
module io_in_buf_wait #(
    parameter int rscid = 1,
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [width-1:0]               dat,
    input  logic                           vld,
    output logic                           rdy,
    output logic [width-1:0]               idat,
    output logic                           ivld,
    input  logic                           irdy
`ifdef IO_IN_BUF_LEVEL_EN
    ,
    output logic [$clog2(depth+1)-1:0]     level,
    output logic [$clog2(depth+1)-1:0]     hwm
`endif
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(depth);

    if (width < 1 || depth < 1 || rscid < 0) begin : g_param_check
        $error("io_in_buf_wait: illegal parameter value");
    end

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rdy_q, rdy_d;
    logic             ivld_q, ivld_d;
    logic [width-1:0] idat_q, idat_d;
    logic             push_s;
    logic             pop_s;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            next_ptr = '0;
        end else begin
            next_ptr = p + PW'(1);
        end
    endfunction

    assign push_s = vld & rdy_q;
    assign pop_s  = ivld_q & irdy;

    // Next-state: storage, pointers, count, and the flags/head word derived from them.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = dat;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Flags and head word are registered from next state, so no input reaches an output combinationally.
        rdy_d  = (count_d < DEPTH_C);
        ivld_d = (count_d != '0);
        idat_d = mem_d[rd_ptr_d];
    end

    // State registers; reset clears storage so the head word reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
            ivld_q   <= 1'b0;
            idat_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
            ivld_q   <= ivld_d;
            idat_q   <= idat_d;
        end
    end

    assign rdy  = rdy_q;
    assign ivld = ivld_q;
    assign idat = idat_q;

`ifdef IO_IN_BUF_LEVEL_EN
    logic [CW-1:0] hwm_q, hwm_d;

    // Peak tracker follows the new occupancy whenever it exceeds the stored peak.
    always_comb begin
        if (count_d > hwm_q) begin
            hwm_d = count_d;
        end else begin
            hwm_d = hwm_q;
        end
    end

    // High-water-mark register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign level = count_q;
    assign hwm   = hwm_q;
`endif

endmodule

// File: tb/tb_io_in_buf_wait.sv
// Directed bench for io_in_buf_wait at depths 4, 3 and 1; inputs driven and outputs sampled on the falling edge.
module tb_io_in_buf_wait;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] d4_dat, d4_idat, d3_dat, d3_idat, d1_dat, d1_idat;
    logic       d4_vld, d4_rdy, d4_ivld, d4_irdy;
    logic       d3_vld, d3_rdy, d3_ivld, d3_irdy;
    logic       d1_vld, d1_rdy, d1_ivld, d1_irdy;
`ifdef IO_IN_BUF_LEVEL_EN
    logic [2:0] d4_level, d4_hwm;
    logic [1:0] d3_level, d3_hwm;
    logic [0:0] d1_level, d1_hwm;
`endif

    int checks = 0;
    int errors = 0;

    io_in_buf_wait #(.rscid(1), .width(8), .depth(4)) u_d4 (
        .clk(clk), .rst(rst), .dat(d4_dat), .vld(d4_vld), .rdy(d4_rdy),
        .idat(d4_idat), .ivld(d4_ivld), .irdy(d4_irdy)
`ifdef IO_IN_BUF_LEVEL_EN
        , .level(d4_level), .hwm(d4_hwm)
`endif
    );

    io_in_buf_wait #(.rscid(2), .width(8), .depth(3)) u_d3 (
        .clk(clk), .rst(rst), .dat(d3_dat), .vld(d3_vld), .rdy(d3_rdy),
        .idat(d3_idat), .ivld(d3_ivld), .irdy(d3_irdy)
`ifdef IO_IN_BUF_LEVEL_EN
        , .level(d3_level), .hwm(d3_hwm)
`endif
    );

    io_in_buf_wait #(.rscid(3), .width(8), .depth(1)) u_d1 (
        .clk(clk), .rst(rst), .dat(d1_dat), .vld(d1_vld), .rdy(d1_rdy),
        .idat(d1_idat), .ivld(d1_ivld), .irdy(d1_irdy)
`ifdef IO_IN_BUF_LEVEL_EN
        , .level(d1_level), .hwm(d1_hwm)
`endif
    );

    task automatic test_reset();
        rst = 1'b1;
        d4_vld = 1'b1; d3_vld = 1'b1; d1_vld = 1'b1;
        d4_dat = 8'hEE; d3_dat = 8'hEE; d1_dat = 8'hEE;
        d4_irdy = 1'b0; d3_irdy = 1'b0; d1_irdy = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (d4_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", d4_rdy); end
        checks++; if (d4_ivld !== 1'b0) begin errors++; $display("FAIL reset_ivld got %b exp 0", d4_ivld); end
        checks++; if (d4_idat !== 8'h00) begin errors++; $display("FAIL reset_idat got %h exp 00", d4_idat); end
        checks++; if (d1_ivld !== 1'b0) begin errors++; $display("FAIL reset_d1_ivld got %b exp 0", d1_ivld); end
        rst = 1'b0;
        d4_vld = 1'b0; d3_vld = 1'b0; d1_vld = 1'b0;
        @(negedge clk);
        checks++; if (d4_rdy !== 1'b1) begin errors++; $display("FAIL release_rdy got %b exp 1", d4_rdy); end
        checks++; if (d4_ivld !== 1'b0) begin errors++; $display("FAIL release_ivld got %b exp 0", d4_ivld); end
        checks++; if (d3_rdy !== 1'b1 || d1_rdy !== 1'b1) begin errors++; $display("FAIL release_rdy_d3_d1 got %b%b exp 11", d3_rdy, d1_rdy); end
    endtask

    task automatic test_fill();
        logic [7:0] w;
        for (int i = 0; i < 4; i++) begin
            w = 8'h11 * 8'(i + 1);
            d4_dat = w; d4_vld = 1'b1; d4_irdy = 1'b0;
            checks++; if (d4_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy[%0d] got %b exp 1", i, d4_rdy); end
            if (i > 0) begin
                checks++; if (d4_ivld !== 1'b1 || d4_idat !== 8'h11) begin errors++; $display("FAIL fill_head[%0d] got %b/%h exp 1/11", i, d4_ivld, d4_idat); end
            end
            @(negedge clk);
        end
        d4_vld = 1'b0;
        checks++; if (d4_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got %b exp 0", d4_rdy); end
        checks++; if (d4_ivld !== 1'b1) begin errors++; $display("FAIL full_ivld got %b exp 1", d4_ivld); end
        checks++; if (d4_idat !== 8'h11) begin errors++; $display("FAIL full_idat got %h exp 11", d4_idat); end
`ifdef IO_IN_BUF_LEVEL_EN
        checks++; if (d4_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", d4_level); end
`endif
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_q [5];
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        d4_irdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d4_vld = (k < 2) ? 1'b1 : 1'b0;
            d4_dat = 8'h55;
            if (k == 0) begin
                checks++; if (d4_rdy !== 1'b0) begin errors++; $display("FAIL fullpop_rdy got %b exp 0", d4_rdy); end
            end else if (k == 1) begin
                checks++; if (d4_rdy !== 1'b1) begin errors++; $display("FAIL fullpop_rdy_rise got %b exp 1", d4_rdy); end
            end
            checks++;
            if (d4_ivld !== 1'b1 || d4_idat !== exp_q[k]) begin
                errors++; $display("FAIL fullpop_order[%0d] got %b/%h exp 1/%h", k, d4_ivld, d4_idat, exp_q[k]);
            end
            @(negedge clk);
        end
        d4_vld = 1'b0;
        checks++; if (d4_ivld !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b exp 0", d4_ivld); end
        d4_irdy = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        d4_irdy = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            d4_vld = (k < 100) ? 1'b1 : 1'b0;
            d4_dat = 8'(k);
            e = 8'(k - 1);
            checks++; if (d4_rdy !== 1'b1) begin errors++; $display("FAIL stream_rdy[%0d] got %b exp 1", k, d4_rdy); end
            checks++;
            if (k == 0) begin
                if (d4_ivld !== 1'b0) begin errors++; $display("FAIL stream_first[%0d] got %b exp 0", k, d4_ivld); end
            end else begin
                if (d4_ivld !== 1'b1 || d4_idat !== e) begin errors++; $display("FAIL stream_data[%0d] got %b/%h exp 1/%h", k, d4_ivld, d4_idat, e); end
            end
`ifdef IO_IN_BUF_LEVEL_EN
            checks++; if (d4_level > 3'd1) begin errors++; $display("FAIL stream_level[%0d] got %0d exp <=1", k, d4_level); end
`endif
            @(negedge clk);
        end
        checks++; if (d4_ivld !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", d4_ivld); end
`ifdef IO_IN_BUF_LEVEL_EN
        checks++; if (d4_hwm !== 3'd1) begin errors++; $display("FAIL stream_hwm got %0d exp 1", d4_hwm); end
`endif
        d4_irdy = 1'b0;
    endtask

    task automatic test_depth3_wrap();
        logic [15:0] vp;
        logic [12:0] ip;
        logic [7:0]  q[$];
        logic        exp_rdy, exp_ivld;
        int          sent, popped, cyc;
        vp = 16'b1011_1110_0111_1011;
        ip = 13'b0_1100_0110_1001;
        sent = 0; popped = 0; cyc = 0;
        while (cyc < 200 && popped < 10) begin
            d3_vld  = (sent < 10) ? vp[cyc % 16] : 1'b0;
            d3_dat  = 8'h30 + 8'(sent);
            d3_irdy = ip[cyc % 13];
            exp_rdy  = (q.size() < 3);
            exp_ivld = (q.size() > 0);
            checks++; if (d3_rdy !== exp_rdy) begin errors++; $display("FAIL wrap_rdy[%0d] got %b exp %b", cyc, d3_rdy, exp_rdy); end
            checks++; if (d3_ivld !== exp_ivld) begin errors++; $display("FAIL wrap_ivld[%0d] got %b exp %b", cyc, d3_ivld, exp_ivld); end
            if (exp_ivld && d3_irdy) begin
                checks++; if (d3_idat !== q[0]) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", cyc, d3_idat, q[0]); end
                void'(q.pop_front());
                popped++;
            end
            if (exp_rdy && d3_vld) begin
                q.push_back(d3_dat);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        d3_vld = 1'b0; d3_irdy = 1'b0;
        checks++; if (popped != 10) begin errors++; $display("FAIL wrap_timeout got %0d words exp 10", popped); end
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        for (int i = 0; i < 3; i++) begin
            w = 8'hC1 + 8'(i);
            d4_dat = w; d4_vld = 1'b1; d4_irdy = 1'b0;
            @(negedge clk);
        end
        d4_vld = 1'b0;
        checks++; if (d4_ivld !== 1'b1 || d4_idat !== 8'hC1) begin errors++; $display("FAIL arst_pre got %b/%h exp 1/c1", d4_ivld, d4_idat); end
        #2 rst = 1'b1;
        #1;
        checks++; if (d4_ivld !== 1'b0) begin errors++; $display("FAIL arst_ivld got %b exp 0", d4_ivld); end
        checks++; if (d4_idat !== 8'h00) begin errors++; $display("FAIL arst_idat got %h exp 00", d4_idat); end
        checks++; if (d4_rdy !== 1'b0) begin errors++; $display("FAIL arst_rdy got %b exp 0", d4_rdy); end
        @(negedge clk);
        rst = 1'b0;
        d4_irdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (d4_ivld !== 1'b0 || d4_rdy !== 1'b1) begin errors++; $display("FAIL arst_after[%0d] got ivld %b rdy %b exp 0 1", k, d4_ivld, d4_rdy); end
        end
        d4_irdy = 1'b0;
    endtask

    task automatic test_depth1();
        logic       m;
        logic [7:0] e;
        int         sent, got, last;
        m = 1'b0; sent = 0; got = 0; last = -1;
        d1_irdy = 1'b1;
        for (int cyc = 0; cyc < 24 && got < 8; cyc++) begin
            d1_vld = (sent < 8) ? 1'b1 : 1'b0;
            d1_dat = 8'hA0 + 8'(sent);
            checks++;
            if (d1_rdy !== ~m || d1_ivld !== m) begin
                errors++; $display("FAIL d1_flags[%0d] got rdy %b ivld %b exp %b %b", cyc, d1_rdy, d1_ivld, ~m, m);
            end
            if (m) begin
                e = 8'hA0 + 8'(got);
                checks++; if (d1_idat !== e) begin errors++; $display("FAIL d1_data[%0d] got %h exp %h", cyc, d1_idat, e); end
                got++;
                last = cyc;
                m = 1'b0;
            end else if (d1_vld) begin
                sent++;
                m = 1'b1;
            end else begin
                m = 1'b0;
            end
            @(negedge clk);
        end
        d1_vld = 1'b0; d1_irdy = 1'b0;
        checks++; if (got != 8 || last != 15) begin errors++; $display("FAIL d1_throughput got %0d words last cycle %0d exp 8 15", got, last); end
    endtask

    initial begin
        rst = 1'b1;
        d4_dat = 8'h00; d3_dat = 8'h00; d1_dat = 8'h00;
        d4_vld = 1'b0; d3_vld = 1'b0; d1_vld = 1'b0;
        d4_irdy = 1'b0; d3_irdy = 1'b0; d1_irdy = 1'b0;
        test_reset();
        test_fill();
        test_full_pop();
        test_stream();
        test_depth3_wrap();
        test_async_reset();
        test_depth1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
